// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl
//   Sits between the UART core FIFOs and the display/LED logic. Each received
//   byte is popped (on a button tick, or automatically in auto mode), held,
//   transformed (+OFFSET, or an ASCII case flip when the optional case-swap
//   feature is built in) and pushed to the TX FIFO once it has room.
//   A shift history of the last HIST_DEPTH received bytes and a count of
//   bytes pushed to TX are kept for display.
//
//   Optional feature macro: UART_ECHO_CASE_EN (adds input case_swap).
//
// Ports
//   clk_100MHz  in   system clock
//   reset_n     in   asynchronous active-low reset
//   btn_tick    in   debounced one-cycle echo request (manual mode)
//   auto_mode   in   1 = echo every received byte without btn_tick
//   rx_empty    in   RX FIFO empty
//   rx_data     in   RX FIFO head word (first-word-fall-through)
//   case_swap   in   (UART_ECHO_CASE_EN only) flip letter case instead of +OFFSET
//   tx_full     in   TX FIFO full
//   read_uart   out  one-cycle RX FIFO pop
//   write_uart  out  one-cycle TX FIFO push
//   tx_data     out  word pushed with write_uart
//   hist_data   out  RX history, newest byte in [DATA_BITS-1:0]
//   byte_count  out  number of bytes pushed to TX (wraps)
//   busy        out  high whenever a transaction is in flight
//
// state | meaning
// IDLE  | waiting for a byte plus a trigger (auto_mode or btn_tick)
// POP   | pop pulse issued; shift held byte into history
// XFORM | compute transformed byte into tx_data
// SEND  | push when TX FIFO has room; hold tx_data while full
module uart_echo_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OFFSET     = 1,
    parameter int HIST_DEPTH = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                            clk_100MHz,
    input  logic                            reset_n,
    input  logic                            btn_tick,
    input  logic                            auto_mode,
    input  logic                            rx_empty,
    input  logic [DATA_BITS-1:0]            rx_data,
`ifdef UART_ECHO_CASE_EN
    input  logic                            case_swap,
`endif
    input  logic                            tx_full,
    output logic                            read_uart,
    output logic                            write_uart,
    output logic [DATA_BITS-1:0]            tx_data,
    output logic [HIST_DEPTH*DATA_BITS-1:0] hist_data,
    output logic [CNT_BITS-1:0]             byte_count,
    output logic                            busy
);

    localparam int HW = HIST_DEPTH * DATA_BITS;
    localparam logic [DATA_BITS-1:0] OFFSET_W = DATA_BITS'(OFFSET);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        XFORM = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  hold_q, hold_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [DATA_BITS-1:0]  tx_q, tx_d;
    logic [HW-1:0]         hist_q, hist_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    logic                  trigger;
    logic [DATA_BITS-1:0]  xform_val;

    assign trigger = !rx_empty && (auto_mode || btn_tick);

`ifdef UART_ECHO_CASE_EN
    logic is_letter;
    assign is_letter = ((hold_q >= 8'h41) && (hold_q <= 8'h5A)) ||
                       ((hold_q >= 8'h61) && (hold_q <= 8'h7A));
    assign xform_val = (case_swap && is_letter) ? (hold_q ^ 8'h20) : (hold_q + OFFSET_W);
`else
    assign xform_val = hold_q + OFFSET_W;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        tx_d    = tx_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    hold_d  = rx_data;
                    read_d  = 1'b1;
                    state_d = POP;
                end
            end
            POP: begin
                // oldest byte falls off the top; shift by a full width leaves 0 for depth 1
                hist_d  = (hist_q << DATA_BITS) | HW'(hold_q);
                state_d = XFORM;
            end
            XFORM: begin
                tx_d    = xform_val;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    write_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            tx_q    <= '0;
            hist_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            read_q  <= read_d;
            write_q <= write_d;
            tx_q    <= tx_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign read_uart  = read_q;
    assign write_uart = write_q;
    assign tx_data    = tx_q;
    assign hist_data  = hist_q;
    assign byte_count = cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
module tb_uart_echo_ctrl;

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic        btn_tick;
    logic        auto_mode;
    logic        rx_empty;
    logic [7:0]  rx_data;
`ifdef UART_ECHO_CASE_EN
    logic        case_swap;
`endif
    logic        tx_full;
    logic        read_uart;
    logic        write_uart;
    logic [7:0]  tx_data;
    logic [31:0] hist_data;
    logic [15:0] byte_count;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_echo_ctrl dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .btn_tick   (btn_tick),
        .auto_mode  (auto_mode),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
`ifdef UART_ECHO_CASE_EN
        .case_swap  (case_swap),
`endif
        .tx_full    (tx_full),
        .read_uart  (read_uart),
        .write_uart (write_uart),
        .tx_data    (tx_data),
        .hist_data  (hist_data),
        .byte_count (byte_count),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One manual-mode echo: returns the pushed byte and the push latency in cycles.
    task automatic do_byte(input logic [7:0] d, output logic [7:0] got, output int lat);
        rx_data  = d;
        rx_empty = 1'b0;
        btn_tick = 1'b1;
        got = 8'h00;
        lat = 0;
        @(negedge clk_100MHz);
        btn_tick = 1'b0;
        rx_empty = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (write_uart) begin
                got = tx_data;
                lat = k;
                break;
            end
            @(negedge clk_100MHz);
        end
        @(negedge clk_100MHz);
    endtask

    initial begin
        logic [7:0] got;
        int         lat;
        int         nw;
        int         nr;
        logic [7:0] caps [6];
        logic [7:0] q [$];

        reset_n   = 1'b0;
        btn_tick  = 1'b0;
        auto_mode = 1'b0;
        rx_empty  = 1'b1;
        rx_data   = 8'h00;
        tx_full   = 1'b0;
`ifdef UART_ECHO_CASE_EN
        case_swap = 1'b0;
`endif
        repeat (3) @(negedge clk_100MHz);
        check("rst_read",  64'(read_uart),  64'h0);
        check("rst_write", 64'(write_uart), 64'h0);
        check("rst_tx",    64'(tx_data),    64'h0);
        check("rst_hist",  64'(hist_data),  64'h0);
        check("rst_cnt",   64'(byte_count), 64'h0);
        check("rst_busy",  64'(busy),       64'h0);
        reset_n = 1'b1;
        @(negedge clk_100MHz);

        // manual echo of 'A' with exact cycle timing
        rx_data  = 8'h41;
        rx_empty = 1'b0;
        btn_tick = 1'b1;
        @(negedge clk_100MHz);
        btn_tick = 1'b0;
        rx_empty = 1'b1;
        check("m_read_n1",  64'(read_uart), 64'h1);
        check("m_busy_n1",  64'(busy),      64'h1);
        @(negedge clk_100MHz);
        check("m_read_n2",  64'(read_uart), 64'h0);
        check("m_hist_n2",  64'(hist_data), 64'h0000_0041);
        @(negedge clk_100MHz);
        check("m_tx_n3",    64'(tx_data),    64'h42);
        check("m_write_n3", 64'(write_uart), 64'h0);
        @(negedge clk_100MHz);
        check("m_write_n4", 64'(write_uart), 64'h1);
        check("m_tx_n4",    64'(tx_data),    64'h42);
        check("m_cnt_n4",   64'(byte_count), 64'h1);
        @(negedge clk_100MHz);
        check("m_write_n5", 64'(write_uart), 64'h0);
        check("m_busy_n5",  64'(busy),       64'h0);

        // 0xFF wraps to 0x00; counter preload wraps to 0
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk_100MHz);
        release dut.cnt_q;
        @(negedge clk_100MHz);
        check("preload_cnt", 64'(byte_count), 64'hFFFF);
        do_byte(8'hFF, got, lat);
        check("wrap_tx",   64'(got),        64'h00);
        check("wrap_lat",  64'(lat),        64'd4);
        check("wrap_cnt",  64'(byte_count), 64'h0);
        check("wrap_hist", 64'(hist_data),  64'h0000_41FF);

        // backpressure: tx_full held 20 cycles in SEND
        tx_full  = 1'b1;
        rx_data  = 8'h30;
        rx_empty = 1'b0;
        btn_tick = 1'b1;
        @(negedge clk_100MHz);
        btn_tick = 1'b0;
        rx_empty = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        for (int c = 0; c < 20; c++) begin
            check("bp_write", 64'(write_uart), 64'h0);
            check("bp_tx",    64'(tx_data),    64'h31);
            @(negedge clk_100MHz);
        end
        check("bp_busy", 64'(busy), 64'h1);
        tx_full = 1'b0;
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_100MHz);
            if (write_uart) nw++;
        end
        check("bp_pulses", 64'(nw),         64'd1);
        check("bp_cnt",    64'(byte_count), 64'h1);

        // auto mode, six queued bytes 'a'..'f'
        q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        rx_data   = q[0];
        rx_empty  = 1'b0;
        auto_mode = 1'b1;
        nw = 0;
        nr = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_100MHz);
            if (read_uart) begin
                nr++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (write_uart) begin
                if (nw < 6) caps[nw] = tx_data;
                nw++;
            end
            rx_empty = (q.size() == 0);
            rx_data  = (q.size() > 0) ? q[0] : 8'h00;
        end
        auto_mode = 1'b0;
        check("auto_pushes", 64'(nw), 64'd6);
        check("auto_pops",   64'(nr), 64'd6);
        for (int i = 0; i < 6; i++) check("auto_tx", 64'(caps[i]), 64'(8'h62 + i));
        check("auto_hist", 64'(hist_data),  64'h6364_6566);
        check("auto_cnt",  64'(byte_count), 64'd7);

        // btn_tick with empty RX FIFO is ignored
        rx_empty = 1'b1;
        btn_tick = 1'b1;
        @(negedge clk_100MHz);
        btn_tick = 1'b0;
        nr = 0;
        for (int c = 0; c < 4; c++) begin
            if (read_uart) nr++;
            @(negedge clk_100MHz);
        end
        check("empty_tick_reads", 64'(nr),   64'd0);
        check("empty_tick_busy",  64'(busy), 64'h0);

        // reset in the middle of a stalled SEND
        tx_full  = 1'b1;
        rx_data  = 8'h55;
        rx_empty = 1'b0;
        btn_tick = 1'b1;
        @(negedge clk_100MHz);
        btn_tick = 1'b0;
        rx_empty = 1'b1;
        repeat (5) @(negedge clk_100MHz);
        reset_n = 1'b0;
        #1;
        check("mrst_busy",  64'(busy),       64'h0);
        check("mrst_tx",    64'(tx_data),    64'h0);
        check("mrst_hist",  64'(hist_data),  64'h0);
        check("mrst_cnt",   64'(byte_count), 64'h0);
        check("mrst_write", 64'(write_uart), 64'h0);
        check("mrst_read",  64'(read_uart),  64'h0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        tx_full = 1'b0;
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_100MHz);
            if (write_uart || read_uart) nw++;
        end
        check("mrst_no_activity", 64'(nw), 64'd0);

`ifdef UART_ECHO_CASE_EN
        case_swap = 1'b1;
        do_byte(8'h71, got, lat);
        check("case_q", 64'(got), 64'h51);
        do_byte(8'h35, got, lat);
        check("case_5", 64'(got), 64'h36);
        do_byte(8'h5A, got, lat);
        check("case_Z", 64'(got), 64'h7A);
        case_swap = 1'b0;
        do_byte(8'h71, got, lat);
        check("nocase_q", 64'(got), 64'h72);
`else
        do_byte(8'h71, got, lat);
        check("plain_q", 64'(got), 64'h72);
        check("plain_lat", 64'(lat), 64'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
